// File: rtl/mc_pkg.sv
// mc_pkg: state encoding and datapath select codes shared by the multicycle controller.
package mc_pkg;
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH
    } state_t;
    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_ORR = 3'b011, ALU_EOR = 3'b100;
    localparam logic [1:0] SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10;
endpackage

// File: rtl/mc_instr_dec.sv
// mc_instr_dec: combinational decode of the live instruction fields into ALU, flag, immediate and PC-write controls.
module mc_instr_dec import mc_pkg::*; (
    input  logic [1:0] Op,
    input  logic [4:0] Funct,
    input  logic [3:0] Rd,
    input  logic       ALUOp,
    input  logic       RegW,
    input  logic       Branch,
    output logic [2:0] ALUControl,
    output logic [1:0] FlagW,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic       PCS
);
    logic [2:0] alu;
    always_comb begin
        alu = Funct[4:1] == 4'b0010 ? ALU_SUB :
              Funct[4:1] == 4'b0000 ? ALU_AND :
              Funct[4:1] == 4'b1100 ? ALU_ORR :
              Funct[4:1] == 4'b0001 ? ALU_EOR : ALU_ADD;
        ALUControl = ALUOp ? alu : ALU_ADD;
        // carry/overflow only mean something for arithmetic ops
        FlagW = ALUOp ? {Funct[0], Funct[0] & (alu == ALU_ADD || alu == ALU_SUB)} : 2'b00;
        ImmSrc = Op;
        RegSrc = {Op == 2'b01 && !Funct[0], Op == 2'b10};
        PCS = (Rd == 4'd15 && RegW) || Branch;
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main FSM sequencing the shared memory port and ALU, with memory-stall timeout.
// Define MULTICYCLE_CTRL_DEBUG_EN to expose state_dbg and the retired-instruction counter.
module multicycle_ctrl import mc_pkg::*; #(
    parameter int ADDR_STALL_MAX = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       mem_ready,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       PCS,
    output logic [1:0] FlagW,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [2:0] ALUControl,
    output logic       timeout
`ifdef MULTICYCLE_CTRL_DEBUG_EN
    ,
    output logic [3:0] state_dbg,
    output logic [15:0] retired_cnt
`endif
);
    localparam logic [7:0] STALL_MAX = 8'(ADDR_STALL_MAX);
    state_t state, state_nx;
    logic alu_op, branch, stall;
    logic [7:0] stall_cnt;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= FETCH;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            FETCH:    state_nx = mem_ready ? DECODE : FETCH;
            DECODE:   state_nx = Op == 2'b00 ? (Funct[5] ? EXECI : EXECR) :
                                 Op == 2'b01 ? MEMADR :
                                 Op == 2'b10 ? BRANCH : FETCH;
            MEMADR:   state_nx = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_nx = mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: state_nx = mem_ready ? FETCH : MEMWRITE;
            EXECR, EXECI: state_nx = ALUWB;
            default:  state_nx = FETCH;
        endcase
    end
    always_comb begin
        IRWrite = 1'b0;
        NextPC = 1'b0;
        AdrSrc = 1'b0;
        ALUSrcA = 1'b0;
        ALUSrcB = SRCB_RD2;
        ResultSrc = RES_ALUOUT;
        RegW = 1'b0;
        MemW = 1'b0;
        alu_op = 1'b0;
        branch = 1'b0;
        case (state)
            FETCH: begin
                // reset forces FETCH, so gate the only mem_ready-driven enables
                IRWrite = mem_ready & reset_n;
                NextPC = mem_ready & reset_n;
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            MEMADR:  ALUSrcB = SRCB_IMM;
            MEMREAD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegW = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                MemW = 1'b1;
            end
            EXECR: alu_op = 1'b1;
            EXECI: begin
                ALUSrcB = SRCB_IMM;
                alu_op = 1'b1;
            end
            ALUWB: RegW = 1'b1;
            BRANCH: begin
                ALUSrcB = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                branch = 1'b1;
            end
            default: ;
        endcase
    end
    mc_instr_dec u_dec (
        .Op(Op),
        .Funct(Funct[4:0]),
        .Rd(Rd),
        .ALUOp(alu_op),
        .RegW(RegW),
        .Branch(branch),
        .ALUControl(ALUControl),
        .FlagW(FlagW),
        .ImmSrc(ImmSrc),
        .RegSrc(RegSrc),
        .PCS(PCS)
    );
    assign stall = (state == FETCH || state == MEMREAD || state == MEMWRITE) && !mem_ready;
    // counter saturates so a stuck memory cannot wrap it; the FSM keeps waiting regardless
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            stall_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            stall_cnt <= stall ? (stall_cnt == STALL_MAX ? stall_cnt : stall_cnt + 8'd1) : 8'd0;
            timeout <= timeout | (stall && stall_cnt == STALL_MAX - 8'd1);
        end
`ifdef MULTICYCLE_CTRL_DEBUG_EN
    assign state_dbg = state;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) retired_cnt <= '0;
        else if (state_nx == FETCH && (state == MEMWB || state == MEMWRITE || state == ALUWB || state == BRANCH))
            retired_cnt <= retired_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized and directed checks of multicycle_ctrl against a per-step behavioural model.
module tb_multicycle_ctrl;
    logic clk = 1'b0, reset_n = 1'b0, mem_ready = 1'b0;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'b0;
    logic [3:0] Rd = 4'b0;
    logic IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, PCS, timeout;
    logic [1:0] ALUSrcB, ResultSrc, FlagW, ImmSrc, RegSrc;
    logic [2:0] ALUControl;
    logic [15:0] act;
    int errors = 0, checks = 0, rw_seen = 0;
    localparam int SF = 0, SD = 1, SMA = 2, SMR = 3, SMWB = 4, SMW = 5, SXR = 6, SXI = 7, SAW = 8, SBR = 9;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .Rd(Rd), .mem_ready(mem_ready),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .PCS(PCS), .FlagW(FlagW), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .ALUControl(ALUControl), .timeout(timeout)
    );

    assign act = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, PCS, FlagW, ALUControl};

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        case (f[4:1])
            4'b0100: return 3'd0;
            4'b0010: return 3'd1;
            4'b0000: return 3'd2;
            4'b1100: return 3'd3;
            4'b0001: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // expected datapath controls for one step of an instruction, read straight off the step table
    function automatic logic [15:0] expect_vec(input int s, input logic rdy, input logic [5:0] f, input logic [3:0] rd);
        logic irw = 1'b0, adr = 1'b0, sa = 1'b0, rw = 1'b0, mw = 1'b0, br = 1'b0, ex = 1'b0;
        logic [1:0] sb = 2'b00, rs = 2'b00, fw;
        logic [2:0] ctl;
        case (s)
            SF:   begin irw = rdy; sa = 1'b1; sb = 2'b10; rs = 2'b10; end
            SD:   begin sa = 1'b1; sb = 2'b10; rs = 2'b10; end
            SMA:  sb = 2'b01;
            SMR:  adr = 1'b1;
            SMWB: begin rs = 2'b01; rw = 1'b1; end
            SMW:  begin adr = 1'b1; mw = 1'b1; end
            SXR:  ex = 1'b1;
            SXI:  begin sb = 2'b01; ex = 1'b1; end
            SAW:  rw = 1'b1;
            SBR:  begin sb = 2'b01; rs = 2'b10; br = 1'b1; end
            default: ;
        endcase
        ctl = ex ? alu_of(f) : 3'd0;
        fw = ex ? {f[0], f[0] & (ctl < 3'd2)} : 2'b00;
        return {irw, adr, sa, sb, rs, irw, rw, mw, (rw && rd == 4'd15) || br, fw, ctl};
    endfunction

    task automatic step(input int s, input logic rdy);
        logic [15:0] exp;
        mem_ready = (s == SF || s == SMR || s == SMW) ? rdy : 1'($urandom);
        #1;
        exp = expect_vec(s, rdy, Funct, Rd);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step s=%0d op=%0d funct=%b rd=%0d: got %h expected %h", s, Op, Funct, Rd, act, exp);
        end
        if (RegW) rw_seen++;
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd, input int fs, input int ms);
        int wb_exp = 0;
        Op = op; Funct = f; Rd = rd; rw_seen = 0;
        repeat (fs) step(SF, 1'b0);
        step(SF, 1'b1);
        step(SD, 1'b0);
        checks++;
        if ({ImmSrc, RegSrc} !== {op, op == 2'b01 && !f[0], op == 2'b10}) begin
            errors++;
            $display("FAIL imm_regsrc op=%0d funct=%b: got %b expected %b", op, f, {ImmSrc, RegSrc}, {op, op == 2'b01 && !f[0], op == 2'b10});
        end
        case (op)
            2'b00: begin step(f[5] ? SXI : SXR, 1'b0); step(SAW, 1'b0); wb_exp = 1; end
            2'b01: begin
                step(SMA, 1'b0);
                repeat (ms) step(f[0] ? SMR : SMW, 1'b0);
                step(f[0] ? SMR : SMW, 1'b1);
                if (f[0]) begin step(SMWB, 1'b0); wb_exp = 1; end
            end
            2'b10: step(SBR, 1'b0);
            default: ;
        endcase
        checks++;
        if (rw_seen !== wb_exp) begin
            errors++;
            $display("FAIL regw_pulses op=%0d funct=%b: got %0d expected %0d", op, f, rw_seen, wb_exp);
        end
    endtask

    task automatic do_reset;
        reset_n = 1'b0; mem_ready = 1'b1; Op = 2'($urandom); Funct = 6'($urandom); Rd = 4'd15;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (act !== expect_vec(SF, 1'b0, Funct, Rd) || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got %h/%b expected %h/0", act, timeout, expect_vec(SF, 1'b0, Funct, Rd));
        end
        reset_n = 1'b1; mem_ready = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        Op = 2'b00; Funct = 6'b001000; Rd = 4'd3;
        step(SF, 1'b1);
        step(SD, 1'b0);
        step(SXR, 1'b0);
        reset_n = 1'b0;
        #1;
        checks++;
        if (RegW !== 1'b0) begin
            errors++;
            $display("FAIL regw_after_reset: got %b expected 0", RegW);
        end
        do_reset;
    endtask

    task automatic test_dp;
        run_instr(2'b00, 6'b001000, 4'd1, 0, 0);
        run_instr(2'b00, 6'b100101, 4'd2, 0, 0);
        run_instr(2'b00, 6'b011001, 4'd3, 1, 0);
        run_instr(2'b00, 6'b000010, 4'd4, 0, 0);
        run_instr(2'b00, 6'b000001, 4'd5, 0, 0);
        run_instr(2'b00, 6'b011111, 4'd6, 2, 0);
    endtask

    task automatic test_ldr; run_instr(2'b01, 6'b011001, 4'd3, 0, 3); endtask
    task automatic test_str; run_instr(2'b01, 6'b011000, 4'd4, 1, 4); endtask

    task automatic test_branch;
        run_instr(2'b10, 6'b100000, 4'd0, 0, 0);
        run_instr(2'b00, 6'b001000, 4'd15, 0, 0);
        run_instr(2'b01, 6'b011001, 4'd15, 0, 1);
    endtask

    task automatic test_illegal; run_instr(2'b11, 6'($urandom), 4'd7, 0, 0); endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++)
            run_instr(2'($urandom), 6'($urandom), 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 4));
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_short_stalls: got %b expected 0", timeout);
        end
    endtask

    task automatic test_stall_boundary;
        do_reset;
        run_instr(2'b00, 6'b001000, 4'd5, 254, 0);
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_254: got %b expected 0", timeout);
        end
        run_instr(2'b01, 6'b011001, 4'd6, 200, 200);
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_cleared_per_wait: got %b expected 0", timeout);
        end
    endtask

    task automatic test_timeout;
        do_reset;
        mem_ready = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (n == 254 || n == 255 || n == 300) begin
                checks++;
                if (timeout !== 1'(n >= 255)) begin
                    errors++;
                    $display("FAIL timeout_at_%0d: got %b expected %b", n, timeout, n >= 255);
                end
            end
        end
    endtask

    task automatic test_reset_mid_write;
        Op = 2'b01; Funct = 6'b011000; Rd = 4'd2;
        step(SF, 1'b1);
        step(SD, 1'b0);
        checks++;
        if (timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got %b expected 1", timeout);
        end
        step(SMA, 1'b0);
        step(SMW, 1'b0);
        mem_ready = 1'b0;
        #1;
        checks++;
        if ({MemW, AdrSrc} !== 2'b11) begin
            errors++;
            $display("FAIL memw_held: got %b expected 11", {MemW, AdrSrc});
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (act !== expect_vec(SF, 1'b0, Funct, Rd) || timeout !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_mid_write: got %h/%b expected %h/0", act, timeout, expect_vec(SF, 1'b0, Funct, Rd));
        end
        @(negedge clk);
        do_reset;
        run_instr(2'b00, 6'b001001, 4'd8, 0, 0);
    endtask

    initial begin
        test_reset;
        test_dp;
        test_ldr;
        test_str;
        test_branch;
        test_illegal;
        test_random;
        test_stall_boundary;
        test_timeout;
        test_reset_mid_write;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
